// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter: serialises one byte per send strobe at CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_engine #(
    parameter  int CLKS_PER_BIT = 10417,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx_status,
    output logic       tx_done,
    output logic       uart_tx
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             parity;
`endif

    assign bit_end = (baud_cnt == LAST_CNT);

    // Line level is registered alongside each state change, so uart_tx always matches the new state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            uart_tx   <= 1'b1;
            tx_status <= 1'b1;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    uart_tx   <= 1'b1;
                    tx_status <= 1'b1;
                    if (tx_en) begin
                        shift     <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity    <= ^tx_data;
`endif
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        uart_tx   <= 1'b0;
                        tx_status <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        uart_tx <= shift[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            uart_tx <= parity;
                            state   <= PARITY;
`else
                            uart_tx <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            // Present the next bit while shifting, since uart_tx is registered.
                            shift   <= shift >> 1;
                            uart_tx <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        uart_tx <= 1'b1;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        uart_tx   <= 1'b1;
                        tx_status <= 1'b1;
                        tx_done   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    uart_tx   <= 1'b1;
                    tx_status <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Randomised self-checking bench for uart_tx_engine with a frame-level reference model.
// Honours UART_TX_PARITY_EN so the same bench covers both builds.
module tb_uart_tx_engine;

    localparam int C = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * C;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_status;
    logic       tx_done;
    logic       uart_tx;

    int total;
    int bad;

    uart_tx_engine #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_status (tx_status),
        .tx_done   (tx_done),
        .uart_tx   (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level k cycles after the accept edge: frame = start, 8 data LSB first, [parity], stop.
    function automatic logic exp_line(input logic [7:0] d, input int k);
        logic [10:0] bits;
        int idx;
`ifdef UART_TX_PARITY_EN
        bits = {1'b1, ^d, d, 1'b0};
`else
        bits = {1'b1, 1'b1, d, 1'b0};
`endif
        idx = k / C;
        if (idx >= NBITS) return 1'b1;
        return bits[idx];
    endfunction

    task automatic test_reset();
        reset   = 1'b1;
        tx_en   = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            total += 3;
            if (uart_tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_line i=%0d got=%b want=1", i, uart_tx); end
            if (tx_status !== 1'b1) begin bad++; $display("[TB] FAIL reset_status i=%0d got=%b want=1", i, tx_status); end
            if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done i=%0d got=%b want=0", i, tx_done); end
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        d       = 8'hA5;
        tx_data = d;
        tx_en   = 1'b1;
        for (int k = 0; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == 0) begin tx_en = 1'b0; tx_data = 8'($urandom); end
            total += 3;
            if (uart_tx !== exp_line(d, k)) begin bad++; $display("[TB] FAIL single_line k=%0d got=%b want=%b", k, uart_tx, exp_line(d, k)); end
            if (tx_status !== (k >= FRAME)) begin bad++; $display("[TB] FAIL single_status k=%0d got=%b want=%b", k, tx_status, k >= FRAME); end
            if (tx_done !== (k == FRAME)) begin bad++; $display("[TB] FAIL single_done k=%0d got=%b want=%b", k, tx_done, k == FRAME); end
        end
    endtask

    task automatic test_busy_ignored();
        logic [7:0] d;
        d       = 8'h3C;
        tx_data = d;
        tx_en   = 1'b1;
        for (int k = 0; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == 0 || k == 41) begin tx_en = 1'b0; tx_data = 8'($urandom); end
            total += 3;
            if (uart_tx !== exp_line(d, k)) begin bad++; $display("[TB] FAIL busy_line k=%0d got=%b want=%b", k, uart_tx, exp_line(d, k)); end
            if (tx_status !== (k >= FRAME)) begin bad++; $display("[TB] FAIL busy_status k=%0d got=%b want=%b", k, tx_status, k >= FRAME); end
            if (tx_done !== (k == FRAME)) begin bad++; $display("[TB] FAIL busy_done k=%0d got=%b want=%b", k, tx_done, k == FRAME); end
            if (k == 40) begin tx_en = 1'b1; tx_data = 8'hFF; end
        end
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            total += 3;
            if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL busy_extra_done i=%0d got=%b want=0", i, tx_done); end
            if (tx_status !== 1'b1) begin bad++; $display("[TB] FAIL busy_after_status i=%0d got=%b want=1", i, tx_status); end
            if (uart_tx !== 1'b1) begin bad++; $display("[TB] FAIL busy_after_line i=%0d got=%b want=1", i, uart_tx); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [2];
        d[0]    = 8'h00;
        d[1]    = 8'hFF;
        tx_data = d[0];
        tx_en   = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k <= FRAME; k++) begin
                @(negedge clk);
                if (k == 0) begin tx_en = 1'b0; tx_data = 8'($urandom); end
                total += 3;
                if (uart_tx !== exp_line(d[f], k)) begin bad++; $display("[TB] FAIL b2b_line f=%0d k=%0d got=%b want=%b", f, k, uart_tx, exp_line(d[f], k)); end
                if (tx_status !== (k >= FRAME)) begin bad++; $display("[TB] FAIL b2b_status f=%0d k=%0d got=%b want=%b", f, k, tx_status, k >= FRAME); end
                if (tx_done !== (k == FRAME)) begin bad++; $display("[TB] FAIL b2b_done f=%0d k=%0d got=%b want=%b", f, k, tx_done, k == FRAME); end
                if (f == 0 && k == FRAME) begin tx_en = 1'b1; tx_data = d[1]; end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d       = 8'h00;
        tx_data = d;
        tx_en   = 1'b1;
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            if (k == 0) tx_en = 1'b0;
            total += 1;
            if (uart_tx !== exp_line(d, k)) begin bad++; $display("[TB] FAIL midrst_line k=%0d got=%b want=%b", k, uart_tx, exp_line(d, k)); end
        end
        reset = 1'b1;
        for (int k = 51; k <= 51 + FRAME + 10; k++) begin
            @(negedge clk);
            reset = 1'b0;
            total += 3;
            if (uart_tx !== 1'b1) begin bad++; $display("[TB] FAIL midrst_idle_line k=%0d got=%b want=1", k, uart_tx); end
            if (tx_status !== 1'b1) begin bad++; $display("[TB] FAIL midrst_idle_status k=%0d got=%b want=1", k, tx_status); end
            if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_idle_done k=%0d got=%b want=0", k, tx_done); end
        end
        d       = 8'h81;
        tx_data = d;
        tx_en   = 1'b1;
        for (int k = 0; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == 0) begin tx_en = 1'b0; tx_data = 8'($urandom); end
            total += 3;
            if (uart_tx !== exp_line(d, k)) begin bad++; $display("[TB] FAIL midrst_resend_line k=%0d got=%b want=%b", k, uart_tx, exp_line(d, k)); end
            if (tx_status !== (k >= FRAME)) begin bad++; $display("[TB] FAIL midrst_resend_status k=%0d got=%b want=%b", k, tx_status, k >= FRAME); end
            if (tx_done !== (k == FRAME)) begin bad++; $display("[TB] FAIL midrst_resend_done k=%0d got=%b want=%b", k, tx_done, k == FRAME); end
        end
    endtask

    // Random bytes with random idle gaps; a gap of zero re-sends in the tx_done cycle.
    task automatic test_random_bytes();
        logic [7:0] d;
        int gap;
        for (int n = 0; n < 8; n++) begin
            d       = 8'($urandom);
            tx_data = d;
            tx_en   = 1'b1;
            for (int k = 0; k <= FRAME; k++) begin
                @(negedge clk);
                if (k == 0) begin tx_en = 1'b0; tx_data = 8'($urandom); end
                total += 3;
                if (uart_tx !== exp_line(d, k)) begin bad++; $display("[TB] FAIL rand_line n=%0d d=%h k=%0d got=%b want=%b", n, d, k, uart_tx, exp_line(d, k)); end
                if (tx_status !== (k >= FRAME)) begin bad++; $display("[TB] FAIL rand_status n=%0d k=%0d got=%b want=%b", n, k, tx_status, k >= FRAME); end
                if (tx_done !== (k == FRAME)) begin bad++; $display("[TB] FAIL rand_done n=%0d k=%0d got=%b want=%b", n, k, tx_done, k == FRAME); end
            end
            gap = int'($urandom_range(0, 5));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                total += 3;
                if (uart_tx !== 1'b1) begin bad++; $display("[TB] FAIL rand_gap_line n=%0d g=%0d got=%b want=1", n, g, uart_tx); end
                if (tx_status !== 1'b1) begin bad++; $display("[TB] FAIL rand_gap_status n=%0d g=%0d got=%b want=1", n, g, tx_status); end
                if (tx_done !== 1'b0) begin bad++; $display("[TB] FAIL rand_gap_done n=%0d g=%0d got=%b want=0", n, g, tx_done); end
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d [2];
        logic       want_par [2];
        d[0] = 8'h07; want_par[0] = 1'b1;
        d[1] = 8'h03; want_par[1] = 1'b0;
        for (int f = 0; f < 2; f++) begin
            tx_data = d[f];
            tx_en   = 1'b1;
            for (int k = 0; k <= FRAME; k++) begin
                @(negedge clk);
                if (k == 0) tx_en = 1'b0;
                total += 3;
                if (uart_tx !== exp_line(d[f], k)) begin bad++; $display("[TB] FAIL par_line f=%0d k=%0d got=%b want=%b", f, k, uart_tx, exp_line(d[f], k)); end
                if (tx_done !== (k == 176)) begin bad++; $display("[TB] FAIL par_done f=%0d k=%0d got=%b want=%b", f, k, tx_done, k == 176); end
                if (k == 9 * C + C / 2 || k == 10 * C + C / 2) begin
                    total += 1;
                    if (uart_tx !== ((k < 10 * C) ? want_par[f] : 1'b1)) begin
                        bad++;
                        $display("[TB] FAIL par_bit f=%0d k=%0d got=%b want=%b", f, k, uart_tx, (k < 10 * C) ? want_par[f] : 1'b1);
                    end
                end else begin
                    total += 1;
                    if (tx_status !== (k >= FRAME)) begin bad++; $display("[TB] FAIL par_status f=%0d k=%0d got=%b want=%b", f, k, tx_status, k >= FRAME); end
                end
            end
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_byte();
        test_busy_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_bytes();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serial transmit end of the CPU's UART link.
- Accepts a byte plus a one-cycle send strobe from the memory-mapped peripheral block (TX data register and send control bit).
- Serialises the byte onto the TX line as 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit, each at a fixed baud period.
- Reports idle/busy back to the peripheral as the TX status bit.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per serial bit (100 MHz / 9600 baud, rounded); must be >= 2.
- CNT_W, $clog2(CLKS_PER_BIT), width of the baud counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only on the accept cycle.
- tx_en  input  1  send strobe; single-cycle pulse from the peripheral.
- tx_status  output  1  1 = idle, ready to accept; 0 = frame in progress.
- tx_done  output  1  one-cycle pulse when a frame's stop bit completes.
- uart_tx  output  1  serial line; idles high.

Behaviour:
- Reset, evaluated at the rising edge:
  - State goes to IDLE, counters clear, shift register clears.
  - Outputs: uart_tx=1, tx_status=1, tx_done=0.
  - Takes priority over every other event.
- Outputs: all are registered, with no combinational path from inputs to outputs.
- States:
  - IDLE: uart_tx=1, tx_status=1.
  - START: uart_tx=0.
  - DATA: uart_tx=shift[0].
  - STOP: uart_tx=1.
  - PARITY (optional feature only).
- Accept:
  - At an edge where state==IDLE and tx_en==1: latch tx_data into the shift register, go to START, clear the baud counter.
  - From the next cycle: tx_status=0 and uart_tx=0.
- Bit timing:
  - The baud counter counts 0..CLKS_PER_BIT-1; each bit is held for exactly CLKS_PER_BIT cycles.
  - At terminal count the counter wraps to 0 and the bit advances.
- START -> DATA after 1 bit period.
- DATA:
  - The shift register shifts right once per bit period.
  - A 3-bit bit counter counts 0..7.
  - After bit 7: DATA -> STOP.
- STOP -> IDLE after 1 bit period.
  - In the first IDLE cycle: tx_status=1 and tx_done=1 for exactly one cycle.
- Latency: the accept edge to the tx_status=1/tx_done cycle is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back:
  - tx_en asserted in the tx_done cycle is accepted.
  - The start bit begins on the next cycle, with zero idle gap after the stop bit.
- tx_en while busy (tx_status=0): ignored. No buffering, and the in-flight frame and latched byte are unchanged.
- tx_data changes after accept: no effect on the current frame.
- Reset mid-frame:
  - The frame is abandoned.
  - uart_tx=1 from the cycle after the reset edge.
  - No tx_done pulse.
- tx_en held high continuously: a new frame starts each time IDLE is entered. This is legal but not the expected usage.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - The line carries the even-parity bit: XOR of the 8 latched data bits, so the total count of ones in data plus parity is even.
  - The parity bit is held for one bit period.
  - Frame length is 11*CLKS_PER_BIT cycles; tx_done timing shifts accordingly.
- Undefined: no PARITY state, no parity logic; 8N1 frame of 10*CLKS_PER_BIT cycles.

Test Plan:
- Reset and idle: reset=1 for 3 cycles, then 0, with no tx_en for 50 cycles -> uart_tx=1, tx_status=1, tx_done=0 throughout.
- Single byte: CLKS_PER_BIT=16, tx_data=0xA5 with a 1-cycle tx_en -> from the next cycle the line carries 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. tx_status=0 for 160 cycles, then tx_done=1 for 1 cycle at cycle 160.
- Busy strobe ignored: 0x3C sent, then tx_en with tx_data=0xFF at cycle 40 -> line bits match 0x3C exactly, and only one tx_done pulse occurs, at cycle 160.
- Back-to-back: send 0x00, then assert tx_en with 0xFF in the tx_done cycle -> 320 contiguous frame cycles with no high gap between the first stop bit and the second start bit. Two tx_done pulses, at 160 and 320.
- Reset mid-frame: send 0x00, assert reset at cycle 50 -> uart_tx=1 and tx_status=1 from cycle 51, and no tx_done. A subsequent send of 0x81 then produces a correct full frame.
- Parity (UART_TX_PARITY_EN): send 0x07 -> the bit after the data bits is 1, the stop bit follows, and tx_done fires at cycle 176. Send 0x03 -> parity bit 0.
